// File: rtl/asrv32_dmem_responder.sv
// asrv32_dmem_responder
// Word-wide data-memory responder for the MEM stage data port. Accepts a
// one-cycle strobe, waits LATENCY cycles, then performs a byte-masked write
// or a full-word read on an internal synchronous RAM and pulses o_ack_data.
// Optional bus-error reporting for out-of-range addresses is enabled by
// defining ASRV32_DMEM_BUSERR_EN; without it the address offset wraps into
// the RAM and o_err stays low.
module asrv32_dmem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb_data,
  input  logic        i_wr_mem_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  input  logic [3:0]  i_wr_mask,
  output logic        o_ack_data,
  output logic [31:0] o_load_word,
  output logic        o_busy,
  output logic        o_err
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_count;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_data;
  logic [3:0]         r_mask;
  logic               r_ack;
  logic [31:0]        r_load;
  logic [31:0]        r_mem [DEPTH];

  logic               w_accept;
  logic               w_access;
  logic [31:0]        w_offset;
  logic [IDX_W-1:0]   w_idx;
  logic               w_oor;

  // Word index comes from the byte offset relative to the RAM base; the
  // two low address bits are dropped because only whole words are handled.
  assign w_offset = r_addr - BASE_ADDR;
  assign w_idx    = w_offset[IDX_W+1:2];

`ifdef ASRV32_DMEM_BUSERR_EN
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);
  logic r_err;

  assign w_oor = (r_addr < BASE_ADDR) || (w_offset >= SPAN);

  // Error flag pulses alongside the ack of an out-of-range access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_access && w_oor;
    end
  end

  assign o_err = r_err;
`else
  // Without bus errors every address wraps into the RAM.
  assign w_oor = 1'b0;
  assign o_err = 1'b0;
`endif

  // Next-state logic: accept a strobe when idle, finish when the count ends.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_access     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_stb_data) begin
          w_accept     = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_count == 4'd1) begin
          w_access     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; a strobe coincident with reset is dropped here.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request capture, latency counter, ack pulse and read-data register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_data  <= 32'd0;
      r_mask  <= 4'd0;
      r_ack   <= 1'b0;
      r_load  <= 32'd0;
    end else begin
      r_ack <= w_access;
      if (w_accept) begin
        r_we    <= i_wr_mem_en;
        r_addr  <= i_addr;
        r_data  <= i_store_data;
        r_mask  <= i_wr_mask;
        r_count <= LAT;
      end else if (r_state == S_WAIT) begin
        r_count <= r_count - 4'd1;
      end
      if (w_access && !r_we) begin
        r_load <= w_oor ? 32'd0 : r_mem[w_idx];
      end
    end
  end

  // Byte-masked RAM write at the completing edge; reset cancels it.
  always_ff @(posedge i_clk) begin
    // NOTE: the RAM array has no reset; clearing it would turn the block
    // into flops and its contents are undefined until written anyway.
    if (w_access && r_we && !w_oor && !i_rst) begin
      for (int b = 0; b < 4; b++) begin
        if (r_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= r_data[8*b +: 8];
        end
      end
    end
  end

  assign o_ack_data  = r_ack;
  assign o_load_word = r_load;
  assign o_busy      = (r_state == S_WAIT);

endmodule

// File: tb/tb_asrv32_dmem_responder.sv
// Testbench for asrv32_dmem_responder. Two instances share the clock and
// reset: instance 0 runs with LATENCY=1, instance 1 with LATENCY=3. A
// word-array reference model tracks RAM contents and the last read word.
module tb_asrv32_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  mask  [2];
  logic        ack   [2];
  logic [31:0] load  [2];
  logic        busy  [2];
  logic        err   [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m     [2][DEPTH];
  bit          known     [2][DEPTH];
  logic [31:0] last_load [2];

  always #5 clk = ~clk;

  asrv32_dmem_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) u_dut_l1 (
    .i_clk(clk), .i_rst(rst), .i_stb_data(stb[0]), .i_wr_mem_en(we[0]),
    .i_addr(addr[0]), .i_store_data(wdata[0]), .i_wr_mask(mask[0]),
    .o_ack_data(ack[0]), .o_load_word(load[0]), .o_busy(busy[0]), .o_err(err[0])
  );

  asrv32_dmem_responder #(.DEPTH(DEPTH), .LATENCY(3), .BASE_ADDR(BASE)) u_dut_l3 (
    .i_clk(clk), .i_rst(rst), .i_stb_data(stb[1]), .i_wr_mem_en(we[1]),
    .i_addr(addr[1]), .i_store_data(wdata[1]), .i_wr_mask(mask[1]),
    .o_ack_data(ack[1]), .o_load_word(load[1]), .o_busy(busy[1]), .o_err(err[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + DEPTH * 4);
  endfunction

  function automatic int index_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 4) % DEPTH);
  endfunction

  // Drives one request at the current negedge and follows it to its ack.
  // Returns at the negedge in which the ack is visible, so a following call
  // places its strobe in the ack cycle.
  task automatic issue(input int d, input bit w, input logic [31:0] a,
                       input logic [31:0] dat, input logic [3:0] m, input string name);
    int          L;
    int          idx;
    bit          exp_err;
    bit          check_data;
    logic [31:0] exp_word;
    L          = lat_of(d);
    idx        = index_of(a);
    check_data = 1'b1;
`ifdef ASRV32_DMEM_BUSERR_EN
    exp_err = !in_range(a);
`else
    exp_err = 1'b0;
`endif
    if (w) begin
      if (!exp_err) begin
        for (int b = 0; b < 4; b++)
          if (m[b]) mem_m[d][idx][8*b +: 8] = dat[8*b +: 8];
        if (m == 4'hF) known[d][idx] = 1'b1;
      end
      exp_word = last_load[d];
    end else begin
      if (exp_err) exp_word = 32'h0;
      else begin
        exp_word   = mem_m[d][idx];
        check_data = known[d][idx];
      end
      last_load[d] = exp_word;
    end

    stb[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = dat; mask[d] = m;
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      stb[d] = 1'b0; addr[d] = $urandom; wdata[d] = $urandom; mask[d] = 4'($urandom);
      we[d] = 1'($urandom);
      total++;
      if (c <= L) begin
        if (ack[d] !== 1'b0 || busy[d] !== 1'b1) begin
          bad++;
          $display("FAIL %s wait d=%0d c=%0d: ack=%b busy=%b, want ack=0 busy=1",
                   name, d, c, ack[d], busy[d]);
        end
      end else begin
        if (ack[d] !== 1'b1 || busy[d] !== 1'b0) begin
          bad++;
          $display("FAIL %s ack d=%0d: ack=%b busy=%b, want ack=1 busy=0",
                   name, d, ack[d], busy[d]);
        end
        total++;
        if (err[d] !== exp_err) begin
          bad++;
          $display("FAIL %s err d=%0d: got %b want %b", name, d, err[d], exp_err);
        end
        if (check_data) begin
          total++;
          if (load[d] !== exp_word) begin
            bad++;
            $display("FAIL %s data d=%0d addr=%h: got %h want %h", name, d, a, load[d], exp_word);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      stb[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; mask[d] = '0;
      last_load[d] = 32'h0;
      for (int i = 0; i < DEPTH; i++) known[d][i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (ack[d] !== 1'b0 || busy[d] !== 1'b0 || err[d] !== 1'b0 || load[d] !== 32'h0) begin
        bad++;
        $display("FAIL reset d=%0d: ack=%b busy=%b err=%b load=%h, want all 0",
                 d, ack[d], busy[d], err[d], load[d]);
      end
    end
  endtask

  task automatic test_latency1();
    issue(0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, "l1_write");
    @(negedge clk);
    total++;
    if (ack[0] !== 1'b0) begin
      bad++;
      $display("FAIL l1_ack_width: ack=%b want 0", ack[0]);
    end
    issue(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, "l1_read");
    total++;
    if (load[0] !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL l1_literal: got %h want deadbeef", load[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_byte_write();
    issue(0, 1'b1, 32'h0000_1004, 32'h1122_3344, 4'hF, "bw_preload");
    @(negedge clk);
    issue(0, 1'b1, 32'h0000_1004, 32'h00AB_0000, 4'b0100, "bw_byte2");
    @(negedge clk);
    issue(0, 1'b1, 32'h0000_1004, 32'hFFFF_FFFF, 4'b0000, "bw_mask0");
    @(negedge clk);
    issue(0, 1'b0, 32'h0000_1006, 32'h0, 4'h0, "bw_read");
    total++;
    if (load[0] !== 32'h11AB_3344) begin
      bad++;
      $display("FAIL bw_literal: got %h want 11ab3344", load[0]);
    end
    @(negedge clk);
  endtask

  // Strobes during WAIT are ignored; a strobe in the ack cycle is accepted.
  task automatic test_busy_ignore();
    bit   exp_ack  [10];
    bit   exp_busy [10];
    logic [31:0] old;
    issue(1, 1'b1, 32'h0000_1000, 32'hA5A5_0F0F, 4'hF, "bi_preload");
    @(negedge clk);
    old = mem_m[1][0];
    for (int c = 0; c < 10; c++) begin
      exp_busy[c] = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
      exp_ack[c]  = (c == 4) || (c == 8);
    end
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(negedge clk);
        total++;
        if (ack[1] !== exp_ack[c] || busy[1] !== exp_busy[c]) begin
          bad++;
          $display("FAIL busy_ignore c=%0d: ack=%b busy=%b, want ack=%b busy=%b",
                   c, ack[1], busy[1], exp_ack[c], exp_busy[c]);
        end
        if (exp_ack[c]) begin
          total++;
          if (load[1] !== old) begin
            bad++;
            $display("FAIL busy_ignore_data c=%0d: got %h want %h", c, load[1], old);
          end
        end
      end
      stb[1] = (c == 0) || (c == 2) || (c == 3) || (c == 4);
      we[1]  = (c == 2) || (c == 3);
      addr[1] = 32'h0000_1000; wdata[1] = 32'h0BAD_0BAD; mask[1] = 4'hF;
    end
    last_load[1] = old;
  endtask

  // Reset in WAIT discards the write; a strobe alongside reset is ignored.
  task automatic test_reset_mid();
    issue(1, 1'b1, 32'h0000_1008, 32'h1234_5678, 4'hF, "rm_preload");
    @(negedge clk);
    stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0000_1008; wdata[1] = 32'h55; mask[1] = 4'hF;
    @(negedge clk);
    rst = 1'b1; we[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0; stb[1] = 1'b0;
    last_load[0] = 32'h0;
    last_load[1] = 32'h0;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (ack[1] !== 1'b0 || busy[1] !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid c=%0d: ack=%b busy=%b, want 0 0", c, ack[1], busy[1]);
      end
      @(negedge clk);
    end
    issue(1, 1'b0, 32'h0000_1008, 32'h0, 4'h0, "rm_read");
    total++;
    if (load[1] !== 32'h1234_5678) begin
      bad++;
      $display("FAIL rm_literal: got %h want 12345678", load[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    issue(0, 1'b1, 32'h0000_1FFC, 32'hCAFE_F00D, 4'hF, "oor_preload");
    @(negedge clk);
    issue(0, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, "oor_read_low");
    @(negedge clk);
    issue(0, 1'b1, 32'h0000_2000, 32'h0BAD_F00D, 4'hF, "oor_write_high");
    @(negedge clk);
    issue(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, "oor_read_word0");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      issue(d, 1'b1, 32'h0000_1000, 32'h1111_0000, 4'hF, "b2b_w0");
      issue(d, 1'b1, 32'h0000_1004, 32'h2222_0004, 4'hF, "b2b_w1");
      issue(d, 1'b0, 32'h0000_1000, 32'h0, 4'h0, "b2b_r0");
      issue(d, 1'b0, 32'h0000_1004, 32'h0, 4'h0, "b2b_r1");
      issue(d, 1'b0, 32'h0000_1000, 32'h0, 4'h0, "b2b_r2");
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          idx;
    int          kind;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) begin
        issue(d, 1'b1, BASE + 32'(i * 4), $urandom, 4'hF, "rnd_preload");
      end
    @(negedge clk);
    for (int n = 0; n < 80; n++) begin
      int d;
      d    = int'($urandom_range(1, 0));
      idx  = int'($urandom_range(15, 0));
      kind = int'($urandom_range(9, 0));
      a    = BASE + 32'(idx * 4) + 32'($urandom_range(3, 0));
      if (kind == 8) a = a + 32'(DEPTH * 4);
      if (kind == 9) a = a - 32'(DEPTH * 4);
      issue(d, 1'($urandom), a, $urandom, 4'($urandom), "rnd");
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency1();
    test_byte_write();
    test_busy_ignore();
    test_reset_mid();
    test_out_of_range();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
